// File: rtl/cpu_pkg.sv
// Shared CPU types: memory op codes, ISA exception codes and MEM-stage FSM states.
package cpu_pkg;

  typedef enum logic [1:0] {
    MEM_OP_NOP = 2'd0,
    MEM_OP_LDW = 2'd1,
    MEM_OP_STW = 2'd2
  } mem_op_e;

  typedef enum logic [2:0] {
    ISA_EXP_NO_EXP      = 3'd0,
    ISA_EXP_EXT_INT     = 3'd1,
    ISA_EXP_UNDEF_INSN  = 3'd2,
    ISA_EXP_OVERFLOW    = 3'd3,
    ISA_EXP_MISS_ALIGN  = 3'd4,
    ISA_EXP_TRAP        = 3'd5,
    ISA_EXP_PRV_VIOLATE = 3'd6
  } isa_exp_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_HOLD = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_ctrl.sv
// MEM-stage bus controller: req/ack handshake FSM, read-data capture while the pipe is stalled.
module mem_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 30
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          acc_i,
  input  logic          rw_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          bus_ack_i,
  input  logic [DW-1:0] bus_rd_data_i,
  output logic          bus_req_o,
  output logic          bus_rw_o,
  output logic [AW-1:0] bus_addr_o,
  output logic [DW-1:0] bus_wr_data_o,
  output logic          busy_o,
  output logic          kill_o,
  output logic [DW-1:0] rd_data_o
);

  mem_state_e    state_q;
  logic [DW-1:0] rdata_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          rw_q;
  logic          killed_q;

  // Outstanding accesses drive the bus from the captured request so a flushed EXE cannot disturb it.
  always_comb begin
    bus_req_o     = 1'b0;
    bus_rw_o      = rw_i;
    bus_addr_o    = addr_i;
    bus_wr_data_o = wr_data_i;
    busy_o        = 1'b0;
    kill_o        = 1'b0;
    rd_data_o     = bus_rd_data_i;
    case (state_q)
      MEM_IDLE: begin
        bus_req_o = acc_i & ~flush_i & rst_n_i;
        busy_o    = bus_req_o & ~bus_ack_i;
      end
      MEM_WAIT: begin
        bus_req_o     = 1'b1;
        bus_rw_o      = rw_q;
        bus_addr_o    = addr_q;
        bus_wr_data_o = wdata_q;
        busy_o        = ~bus_ack_i;
        kill_o        = killed_q | flush_i;
      end
      MEM_HOLD: rd_data_o = rdata_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= MEM_IDLE;
      rdata_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rw_q     <= 1'b0;
      killed_q <= 1'b0;
    end else begin
      case (state_q)
        MEM_IDLE: begin
          if (bus_req_o) begin
            addr_q   <= addr_i;
            wdata_q  <= wr_data_i;
            rw_q     <= rw_i;
            killed_q <= 1'b0;
            if (!bus_ack_i) begin
              state_q <= MEM_WAIT;
            end else if (stall_i) begin
              rdata_q <= bus_rd_data_i;
              state_q <= MEM_HOLD;
            end
          end
        end
        MEM_WAIT: begin
          if (flush_i) killed_q <= 1'b1;
          if (bus_ack_i) begin
            if (kill_o) begin
              state_q <= MEM_IDLE;
            end else begin
              rdata_q <= bus_rd_data_i;
              state_q <= stall_i ? MEM_HOLD : MEM_IDLE;
            end
          end
        end
        MEM_HOLD: begin
          if (flush_i || !stall_i) state_q <= MEM_IDLE;
        end
        default: state_q <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: misalign check, bus access via mem_ctrl, MEM->WB pipeline register.
// Optional feature: define MEM_MISALIGN_EXP_EN to raise a misalign exception instead of accessing.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int unsigned WORD_DATA_WIDTH = 32,
  parameter int unsigned WORD_ADDR_WIDTH = 30,
  parameter int unsigned MEM_OP_BUS      = 2,
  parameter int unsigned CTRL_OP_BUS     = 2,
  parameter int unsigned REG_ADDR_BUS    = 5,
  parameter int unsigned ISA_EXP_BUS     = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  output logic                       busy_o,
  output logic [WORD_DATA_WIDTH-1:0] fwd_data_o,
  input  logic [WORD_ADDR_WIDTH-1:0] exe_pc_i,
  input  logic                       exe_en_i,
  input  logic                       exe_br_flag_i,
  input  logic [MEM_OP_BUS-1:0]      exe_mem_op_i,
  input  logic [WORD_DATA_WIDTH-1:0] exe_mem_wr_data_i,
  input  logic [CTRL_OP_BUS-1:0]     exe_ctrl_op_i,
  input  logic [REG_ADDR_BUS-1:0]    exe_dst_addr_i,
  input  logic                       exe_gpr_wre_i,
  input  logic [ISA_EXP_BUS-1:0]     exe_exp_code_i,
  input  logic [WORD_DATA_WIDTH-1:0] exe_out_i,
  output logic                       bus_req_o,
  output logic                       bus_rw_o,
  output logic [WORD_ADDR_WIDTH-1:0] bus_addr_o,
  output logic [WORD_DATA_WIDTH-1:0] bus_wr_data_o,
  input  logic [WORD_DATA_WIDTH-1:0] bus_rd_data_i,
  input  logic                       bus_ack_i,
  output logic [WORD_ADDR_WIDTH-1:0] mem_pc_o,
  output logic                       mem_en_o,
  output logic                       mem_br_flag_o,
  output logic [CTRL_OP_BUS-1:0]     mem_ctrl_op_o,
  output logic [REG_ADDR_BUS-1:0]    mem_dst_addr_o,
  output logic                       mem_gpr_wre_o,
  output logic [ISA_EXP_BUS-1:0]     mem_exp_code_o,
  output logic [WORD_DATA_WIDTH-1:0] mem_out_o
);

  localparam logic [ISA_EXP_BUS-1:0] NO_EXP    = ISA_EXP_BUS'(ISA_EXP_NO_EXP);
  localparam logic [ISA_EXP_BUS-1:0] MISS_ALGN = ISA_EXP_BUS'(ISA_EXP_MISS_ALIGN);

  logic                       is_mem;
  logic                       is_ldw;
  logic                       misalign;
  logic                       acc;
  logic                       kill;
  logic [WORD_DATA_WIDTH-1:0] rd_data;

  always_comb begin
    is_mem = exe_mem_op_i != MEM_OP_BUS'(MEM_OP_NOP);
    is_ldw = exe_mem_op_i == MEM_OP_BUS'(MEM_OP_LDW);
`ifdef MEM_MISALIGN_EXP_EN
    misalign = is_mem & (exe_out_i[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    acc = exe_en_i & is_mem & ~misalign & (exe_exp_code_i == NO_EXP);
  end

  mem_ctrl #(
    .DW(WORD_DATA_WIDTH),
    .AW(WORD_ADDR_WIDTH)
  ) u_mem_ctrl (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .acc_i         (acc),
    .rw_i          (is_ldw),
    .addr_i        (exe_out_i[WORD_ADDR_WIDTH+1:2]),
    .wr_data_i     (exe_mem_wr_data_i),
    .bus_ack_i     (bus_ack_i),
    .bus_rd_data_i (bus_rd_data_i),
    .bus_req_o     (bus_req_o),
    .bus_rw_o      (bus_rw_o),
    .bus_addr_o    (bus_addr_o),
    .bus_wr_data_o (bus_wr_data_o),
    .busy_o        (busy_o),
    .kill_o        (kill),
    .rd_data_o     (rd_data)
  );

  // A result whose access was flushed mid-wait is dropped as a bubble even when the ack lands later.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem_pc_o       <= '0;
      mem_en_o       <= 1'b0;
      mem_br_flag_o  <= 1'b0;
      mem_ctrl_op_o  <= '0;
      mem_dst_addr_o <= '0;
      mem_gpr_wre_o  <= 1'b0;
      mem_exp_code_o <= NO_EXP;
      mem_out_o      <= '0;
    end else if (flush_i || kill) begin
      mem_pc_o       <= '0;
      mem_en_o       <= 1'b0;
      mem_br_flag_o  <= 1'b0;
      mem_ctrl_op_o  <= '0;
      mem_dst_addr_o <= '0;
      mem_gpr_wre_o  <= 1'b0;
      mem_exp_code_o <= NO_EXP;
      mem_out_o      <= '0;
    end else if (!(stall_i || busy_o)) begin
      mem_pc_o       <= exe_pc_i;
      mem_en_o       <= exe_en_i;
      mem_br_flag_o  <= exe_br_flag_i;
      mem_ctrl_op_o  <= exe_ctrl_op_i;
      mem_dst_addr_o <= exe_dst_addr_i;
      mem_gpr_wre_o  <= exe_gpr_wre_i & ~misalign;
      mem_exp_code_o <= (misalign && exe_exp_code_i == NO_EXP) ? MISS_ALGN : exe_exp_code_i;
      mem_out_o      <= (is_ldw && acc) ? rd_data : exe_out_i;
    end
  end

  assign fwd_data_o = mem_out_o;

endmodule
